hyperbus_wb_bridge: RTL and testbench
=====================================

Name: hyperbus_wb_bridge

Overview:
Wishbone B4 classic 32-bit slave that converts single bus accesses into HyperBus controller transactions of two 16-bit words (controller WIDTH=8). It sits directly upstream of the hyperbus controller: it drives the controller's adr_i/dat_i/mask_i/wrq/rrq/reg_space_i and consumes its ready/valid/dat_o. It adds byte-lane masking, little-endian halfword ordering, and a read timeout that produces a bus error.

Parameters:
ADDR_LENGTH, 32, controller word-address width (hb_adr_o width).
REG_SEL_BIT, 31, wb_adr_i bit that selects HyperRAM register space.
TIMEOUT_CYCLES, 64, maximum clk cycles from rrq assertion to second valid before error; must be ≥4.

Ports:
clk  in  1  controller memory clock; the only clock.
rstn  in  1  asynchronous active-low reset.
wb_cyc_i  in  1  Wishbone cycle.
wb_stb_i  in  1  Wishbone strobe.
wb_we_i  in  1  1=write, 0=read.
wb_adr_i  in  32  byte address; bits [1:0] ignored.
wb_dat_i  in  32  write data.
wb_sel_i  in  4  byte enables.
wb_dat_o  out  32  read data.
wb_ack_o  out  1  single-cycle acknowledge.
wb_err_o  out  1  single-cycle error (read timeout).
hb_adr_o  out  ADDR_LENGTH  controller word address.
hb_dat_o  out  16  write word to controller dat_i.
hb_mask_o  out  3  to controller mask_i; bit2 always 0; bits [1:0] 1=byte masked.
hb_reg_space_o  out  1  to controller reg_space_i.
hb_wrq_o  out  1  write request.
hb_rrq_o  out  1  read request.
hb_ready_i  in  1  controller ready (high while in write data phase).
hb_valid_i  in  1  controller read word valid, one-cycle pulse.
hb_dat_i  in  16  controller read word.

Behaviour:
- Reset (rstn low, async): state IDLE; wb_ack_o=0, wb_err_o=0, wb_dat_o=0, hb_wrq_o=0, hb_rrq_o=0, hb_adr_o=0, hb_reg_space_o=0; hb_mask_o=3'b011 and hb_dat_o=0 (combinational in IDLE).
- All outputs registered except hb_dat_o/hb_mask_o, which are combinational muxes from registered state and latched write data.
- States: IDLE, WR0, WR1, WR_END, RD0, RD1, DONE, ERR.
- IDLE: on wb_cyc_i & wb_stb_i & !wb_ack_o & !wb_err_o, latch wb_dat_i, wb_sel_i, wb_we_i; set hb_adr_o = {wb_adr_i[ADDR_LENGTH-1:2],1'b0} zero-extended as word address = byte address >>1 with bit0 cleared; hb_reg_space_o = wb_adr_i[REG_SEL_BIT]. we=1 → WR0, assert hb_wrq_o; we=0 → RD0, assert hb_rrq_o, clear timeout counter.
- WR0: hb_dat_o = data[15:0], hb_mask_o = {1'b0, ~sel[1], ~sel[0]}. On hb_ready_i → WR1.
- WR1: hb_dat_o = data[31:16], hb_mask_o = {1'b0, ~sel[3], ~sel[2]}. Next cycle unconditionally (ready stays high in controller write phase) → WR_END with hb_wrq_o deasserted.
- WR_END: hb_mask_o=3'b011 (all masked), hb_wrq_o=0 → DONE.
- RD0: first hb_valid_i latches hb_dat_i into wb_dat_o[15:0] → RD1. RD1: next hb_valid_i latches into wb_dat_o[31:16], deasserts hb_rrq_o → DONE.
- Timeout: counter runs in RD0/RD1; reaching TIMEOUT_CYCLES-1 without completion → deassert hb_rrq_o → ERR.
- DONE: wb_ack_o=1 for exactly one cycle if wb_cyc_i still high, else suppressed → IDLE. ERR: wb_err_o=1 one cycle (same cyc gating) → IDLE.
- hb_wrq_o/hb_rrq_o are low for ≥1 cycle between transactions (DONE/ERR/IDLE); back-to-back throughput is limited by controller idle gap only.
- wb_cyc_i dropped mid-transaction: hyperbus transaction completes normally; no ack/err issued.
- Extra hb_valid_i outside RD0/RD1 is ignored.
- wb_sel_i=0 write: full transaction with both words masked; acked normally.

Decomposition:
- Package hyperbus_pkg: state encoding constants (one-hot, 8 states), HB_WORD_WIDTH=16, MASK_ALL=3'b011.
- Sub-module hyperbus_timeout: resettable up-counter with terminal-count flag; width $clog2(TIMEOUT_CYCLES).

Test Plan:
- Write 0x1234_5678 to byte adr 0x0000_0100, sel=4'hF → hb_adr_o=0x80, words 0x5678 then 0x1234, mask 3'b000 both, one wb_ack_o.
- Write sel=4'b0100, adr 0x10 → word0 mask 3'b011, word1 mask 3'b010; ack.
- Read adr 0x20, controller returns valid 0xBEEF then 0xDEAD → wb_dat_o=0xDEAD_BEEF, hb_adr_o=0x10, ack one cycle after second valid.
- Read with adr bit31=1 → hb_reg_space_o=1, hb_adr_o bits from wb_adr_i[ADDR_LENGTH-1:1] only.
- Read, controller never pulses valid → hb_rrq_o drops at cycle 64, wb_err_o one cycle, no ack.
- rstn low during WR1 → hb_wrq_o=0, state IDLE immediately; next write completes correctly.

Source files
------------

// File: rtl/hyperbus_pkg.sv
// Shared types and constants for the Wishbone-to-HyperBus bridge.
// One-hot FSM state encoding, controller word width and idle mask.
package hyperbus_pkg;

   localparam int HB_WORD_WIDTH = 16;
   localparam logic [2:0] MASK_ALL = 3'b011;

   typedef enum logic [7:0] {
      S_IDLE   = 8'b0000_0001,
      S_WR0    = 8'b0000_0010,
      S_WR1    = 8'b0000_0100,
      S_WR_END = 8'b0000_1000,
      S_RD0    = 8'b0001_0000,
      S_RD1    = 8'b0010_0000,
      S_DONE   = 8'b0100_0000,
      S_ERR    = 8'b1000_0000
   } state_e;

endpackage

// File: rtl/hyperbus_wb_bridge_if.sv
// Wishbone slave bus plus HyperBus controller request/response signals.
// slave: bridge view; master: bus master / controller view.
interface hyperbus_wb_bridge_if #(
   parameter int ADDR_LENGTH = 32
);
   import hyperbus_pkg::*;

   logic                     wb_cyc_i;
   logic                     wb_stb_i;
   logic                     wb_we_i;
   logic [31:0]              wb_adr_i;
   logic [31:0]              wb_dat_i;
   logic [3:0]               wb_sel_i;
   logic [31:0]              wb_dat_o;
   logic                     wb_ack_o;
   logic                     wb_err_o;
   logic [ADDR_LENGTH-1:0]   hb_adr_o;
   logic [HB_WORD_WIDTH-1:0] hb_dat_o;
   logic [2:0]               hb_mask_o;
   logic                     hb_reg_space_o;
   logic                     hb_wrq_o;
   logic                     hb_rrq_o;
   logic                     hb_ready_i;
   logic                     hb_valid_i;
   logic [HB_WORD_WIDTH-1:0] hb_dat_i;

   modport slave (
      input  wb_cyc_i, wb_stb_i, wb_we_i,
      input  wb_adr_i, wb_dat_i, wb_sel_i,
      output wb_dat_o, wb_ack_o, wb_err_o,
      output hb_adr_o, hb_dat_o, hb_mask_o,
      output hb_reg_space_o, hb_wrq_o, hb_rrq_o,
      input  hb_ready_i, hb_valid_i, hb_dat_i
   );

   modport master (
      output wb_cyc_i, wb_stb_i, wb_we_i,
      output wb_adr_i, wb_dat_i, wb_sel_i,
      input  wb_dat_o, wb_ack_o, wb_err_o,
      input  hb_adr_o, hb_dat_o, hb_mask_o,
      input  hb_reg_space_o, hb_wrq_o, hb_rrq_o,
      output hb_ready_i, hb_valid_i, hb_dat_i
   );

endinterface

// File: rtl/hyperbus_timeout.sv
// Read timeout counter: clr_i zeroes, en_i counts up to TIMEOUT_CYCLES-1.
// Ports: clk, rstn, clr_i, en_i, tc_o (terminal count reached).
module hyperbus_timeout #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic clk,
   input  logic rstn,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   localparam int W = $clog2(TIMEOUT_CYCLES);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   assign tc_o = (cnt_q == W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (en_i && !tc_o)
         cnt_d = cnt_q + W'(1);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/hyperbus_wb_bridge.sv
// Wishbone 32-bit slave to HyperBus controller bridge (two 16-bit words).
// Ports: clk, rstn, bus (wishbone slave side + hyperbus controller side).
module hyperbus_wb_bridge
   import hyperbus_pkg::*;
#(
   parameter int ADDR_LENGTH    = 32,
   parameter int REG_SEL_BIT    = 31,
   parameter int TIMEOUT_CYCLES = 64
) (
   input logic                 clk,
   input logic                 rstn,
   hyperbus_wb_bridge_if.slave bus
);

   state_e                 state_q, state_d;
   logic [31:0]            dat_q, dat_d;
   logic [3:0]             sel_q, sel_d;
   logic [ADDR_LENGTH-1:0] adr_q, adr_d;
   logic                   reg_q, reg_d;
   logic                   wrq_q, wrq_d;
   logic                   rrq_q, rrq_d;
   logic                   ack_q, ack_d;
   logic                   err_q, err_d;
   logic [31:0]            rdat_q, rdat_d;
   logic                   lost_q, lost_d;
   logic                   tmr_clr, tmr_en, tmo;
   logic                   req, cyc_ok;
   logic [ADDR_LENGTH-1:0] word_adr;
   logic                   unused_adr_lsb;

   assign unused_adr_lsb = ^bus.wb_adr_i[1:0];

   // Byte address >> 1 with bit0 cleared: 32-bit access = 2 HB words.
   assign word_adr = {1'b0, bus.wb_adr_i[ADDR_LENGTH-1:2], 1'b0};

   assign req = bus.wb_cyc_i & bus.wb_stb_i & ~ack_q & ~err_q;

   // A master that let go of cyc at any point gets no response,
   // even if it raises cyc again before the HB transfer finishes.
   assign cyc_ok = bus.wb_cyc_i & ~lost_q;

   hyperbus_timeout #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_tmo (
      .clk  (clk),
      .rstn (rstn),
      .clr_i(tmr_clr),
      .en_i (tmr_en),
      .tc_o (tmo)
   );

   always_comb begin
      state_d = state_q;
      dat_d   = dat_q;
      sel_d   = sel_q;
      adr_d   = adr_q;
      reg_d   = reg_q;
      wrq_d   = wrq_q;
      rrq_d   = rrq_q;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      rdat_d  = rdat_q;
      lost_d  = lost_q | (~bus.wb_cyc_i & (state_q != S_IDLE));
      tmr_clr = 1'b0;
      tmr_en  = 1'b0;
      bus.hb_dat_o  = '0;
      bus.hb_mask_o = MASK_ALL;
      unique case (state_q)
         S_IDLE: begin
            lost_d = 1'b0;
            if (req) begin
               dat_d = bus.wb_dat_i;
               sel_d = bus.wb_sel_i;
               adr_d = word_adr;
               reg_d = bus.wb_adr_i[REG_SEL_BIT];
               if (bus.wb_we_i) begin
                  wrq_d   = 1'b1;
                  state_d = S_WR0;
               end else begin
                  rrq_d   = 1'b1;
                  tmr_clr = 1'b1;
                  state_d = S_RD0;
               end
            end
         end
         S_WR0: begin
            bus.hb_dat_o  = dat_q[15:0];
            bus.hb_mask_o = {1'b0, ~sel_q[1], ~sel_q[0]};
            if (bus.hb_ready_i)
               state_d = S_WR1;
         end
         S_WR1: begin
            bus.hb_dat_o  = dat_q[31:16];
            bus.hb_mask_o = {1'b0, ~sel_q[3], ~sel_q[2]};
            wrq_d   = 1'b0;
            state_d = S_WR_END;
         end
         S_WR_END: begin
            ack_d   = cyc_ok;
            state_d = S_DONE;
         end
         S_RD0: begin
            tmr_en = 1'b1;
            if (tmo) begin
               rrq_d   = 1'b0;
               err_d   = cyc_ok;
               state_d = S_ERR;
            end else if (bus.hb_valid_i) begin
               rdat_d[15:0] = bus.hb_dat_i;
               state_d      = S_RD1;
            end
         end
         S_RD1: begin
            tmr_en = 1'b1;
            if (bus.hb_valid_i) begin
               rdat_d[31:16] = bus.hb_dat_i;
               rrq_d   = 1'b0;
               ack_d   = cyc_ok;
               state_d = S_DONE;
            end else if (tmo) begin
               rrq_d   = 1'b0;
               err_d   = cyc_ok;
               state_d = S_ERR;
            end
         end
         S_DONE:  state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         dat_q   <= '0;
         sel_q   <= '0;
         adr_q   <= '0;
         reg_q   <= 1'b0;
         wrq_q   <= 1'b0;
         rrq_q   <= 1'b0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         rdat_q  <= '0;
         lost_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         dat_q   <= dat_d;
         sel_q   <= sel_d;
         adr_q   <= adr_d;
         reg_q   <= reg_d;
         wrq_q   <= wrq_d;
         rrq_q   <= rrq_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         rdat_q  <= rdat_d;
         lost_q  <= lost_d;
      end
   end

   assign bus.wb_dat_o       = rdat_q;
   assign bus.wb_ack_o       = ack_q;
   assign bus.wb_err_o       = err_q;
   assign bus.hb_adr_o       = adr_q;
   assign bus.hb_reg_space_o = reg_q;
   assign bus.hb_wrq_o       = wrq_q;
   assign bus.hb_rrq_o       = rrq_q;

endmodule

// File: tb/tb_hyperbus_wb_bridge.sv
// Directed bench for hyperbus_wb_bridge: writes, reads, register space,
// read timeout, dropped cycle and asynchronous reset mid-write.
module tb_hyperbus_wb_bridge;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   hyperbus_wb_bridge_if bus ();

   hyperbus_wb_bridge dut (
      .clk (clk),
      .rstn(rstn),
      .bus (bus)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wb_start(input logic we, input logic [31:0] adr,
                           input logic [31:0] dat, input logic [3:0] sel);
      bus.wb_cyc_i = 1'b1;
      bus.wb_stb_i = 1'b1;
      bus.wb_we_i  = we;
      bus.wb_adr_i = adr;
      bus.wb_dat_i = dat;
      bus.wb_sel_i = sel;
   endtask

   task automatic wb_drop();
      bus.wb_cyc_i = 1'b0;
      bus.wb_stb_i = 1'b0;
   endtask

   initial begin
      bus.wb_cyc_i   = 1'b0;
      bus.wb_stb_i   = 1'b0;
      bus.wb_we_i    = 1'b0;
      bus.wb_adr_i   = '0;
      bus.wb_dat_i   = '0;
      bus.wb_sel_i   = '0;
      bus.hb_ready_i = 1'b0;
      bus.hb_valid_i = 1'b0;
      bus.hb_dat_i   = '0;

      // Reset state
      tick();
      tick();
      chk("rst_ack", bus.wb_ack_o, 0);
      chk("rst_err", bus.wb_err_o, 0);
      chk("rst_dat", bus.wb_dat_o, 0);
      chk("rst_wrq", bus.hb_wrq_o, 0);
      chk("rst_rrq", bus.hb_rrq_o, 0);
      chk("rst_adr", bus.hb_adr_o, 0);
      chk("rst_reg", bus.hb_reg_space_o, 0);
      chk("rst_mask", bus.hb_mask_o, 3'b011);
      chk("rst_hbdat", bus.hb_dat_o, 0);
      rstn = 1'b1;
      tick();

      // Full-word write
      wb_start(1'b1, 32'h0000_0100, 32'h1234_5678, 4'hF);
      tick();
      chk("w1_wrq", bus.hb_wrq_o, 1);
      chk("w1_adr", bus.hb_adr_o, 32'h80);
      chk("w1_d0", bus.hb_dat_o, 16'h5678);
      chk("w1_m0", bus.hb_mask_o, 3'b000);
      chk("w1_ack_early", bus.wb_ack_o, 0);
      bus.hb_ready_i = 1'b1;
      tick();
      chk("w1_d1", bus.hb_dat_o, 16'h1234);
      chk("w1_m1", bus.hb_mask_o, 3'b000);
      chk("w1_wrq1", bus.hb_wrq_o, 1);
      tick();
      bus.hb_ready_i = 1'b0;
      chk("w1_wrq_end", bus.hb_wrq_o, 0);
      chk("w1_m_end", bus.hb_mask_o, 3'b011);
      chk("w1_ack_end", bus.wb_ack_o, 0);
      tick();
      chk("w1_ack", bus.wb_ack_o, 1);
      wb_drop();
      tick();
      chk("w1_ack_once", bus.wb_ack_o, 0);

      // Partial write, only byte 2 enabled
      wb_start(1'b1, 32'h0000_0010, 32'hAABB_CCDD, 4'b0100);
      tick();
      chk("w2_adr", bus.hb_adr_o, 32'h8);
      chk("w2_d0", bus.hb_dat_o, 16'hCCDD);
      chk("w2_m0", bus.hb_mask_o, 3'b011);
      bus.hb_ready_i = 1'b1;
      tick();
      chk("w2_d1", bus.hb_dat_o, 16'hAABB);
      chk("w2_m1", bus.hb_mask_o, 3'b010);
      bus.hb_ready_i = 1'b0;
      tick();
      tick();
      chk("w2_ack", bus.wb_ack_o, 1);
      wb_drop();
      tick();

      // Read with two valid words
      wb_start(1'b0, 32'h0000_0020, 32'h0, 4'hF);
      tick();
      chk("r1_rrq", bus.hb_rrq_o, 1);
      chk("r1_adr", bus.hb_adr_o, 32'h10);
      chk("r1_reg", bus.hb_reg_space_o, 0);
      tick();
      tick();
      bus.hb_valid_i = 1'b1;
      bus.hb_dat_i   = 16'hBEEF;
      tick();
      bus.hb_valid_i = 1'b0;
      chk("r1_rrq_mid", bus.hb_rrq_o, 1);
      chk("r1_ack_mid", bus.wb_ack_o, 0);
      tick();
      bus.hb_valid_i = 1'b1;
      bus.hb_dat_i   = 16'hDEAD;
      tick();
      bus.hb_valid_i = 1'b0;
      chk("r1_ack", bus.wb_ack_o, 1);
      chk("r1_dat", bus.wb_dat_o, 32'hDEAD_BEEF);
      chk("r1_rrq_off", bus.hb_rrq_o, 0);
      wb_drop();
      tick();
      chk("r1_ack_once", bus.wb_ack_o, 0);

      // Stray valid while idle is ignored
      bus.hb_valid_i = 1'b1;
      bus.hb_dat_i   = 16'h1111;
      tick();
      bus.hb_valid_i = 1'b0;
      tick();
      chk("stray_dat", bus.wb_dat_o, 32'hDEAD_BEEF);
      chk("stray_ack", bus.wb_ack_o, 0);

      // Register-space read
      wb_start(1'b0, 32'h8000_0040, 32'h0, 4'hF);
      tick();
      chk("r2_reg", bus.hb_reg_space_o, 1);
      chk("r2_adr", bus.hb_adr_o, 32'h4000_0020);
      bus.hb_valid_i = 1'b1;
      bus.hb_dat_i   = 16'h0001;
      tick();
      bus.hb_dat_i   = 16'h0002;
      tick();
      bus.hb_valid_i = 1'b0;
      chk("r2_ack", bus.wb_ack_o, 1);
      chk("r2_dat", bus.wb_dat_o, 32'h0002_0001);
      wb_drop();
      tick();

      // Read timeout
      wb_start(1'b0, 32'h0000_0004, 32'h0, 4'hF);
      tick();
      chk("to_rrq0", bus.hb_rrq_o, 1);
      repeat (63) tick();
      chk("to_rrq63", bus.hb_rrq_o, 1);
      chk("to_err_early", bus.wb_err_o, 0);
      tick();
      chk("to_rrq64", bus.hb_rrq_o, 0);
      chk("to_err", bus.wb_err_o, 1);
      chk("to_noack", bus.wb_ack_o, 0);
      wb_drop();
      tick();
      chk("to_err_once", bus.wb_err_o, 0);

      // Cycle dropped mid-write: transfer finishes, no ack
      wb_start(1'b1, 32'h0000_0000, 32'h0000_0001, 4'hF);
      tick();
      wb_drop();
      bus.hb_ready_i = 1'b1;
      tick();
      bus.hb_ready_i = 1'b0;
      tick();
      chk("drop_wrq", bus.hb_wrq_o, 0);
      tick();
      chk("drop_noack", bus.wb_ack_o, 0);
      tick();

      // Asynchronous reset during second write word
      wb_start(1'b1, 32'h0000_0040, 32'h5555_AAAA, 4'hF);
      tick();
      bus.hb_ready_i = 1'b1;
      tick();
      chk("rw_wrq_pre", bus.hb_wrq_o, 1);
      rstn = 1'b0;
      #1;
      chk("rw_wrq_rst", bus.hb_wrq_o, 0);
      chk("rw_mask_rst", bus.hb_mask_o, 3'b011);
      chk("rw_dat_rst", bus.hb_dat_o, 0);
      bus.hb_ready_i = 1'b0;
      wb_drop();
      tick();
      rstn = 1'b1;
      tick();

      // Write after reset completes normally
      wb_start(1'b1, 32'h0000_0200, 32'hCAFE_F00D, 4'hF);
      tick();
      chk("pw_adr", bus.hb_adr_o, 32'h100);
      chk("pw_d0", bus.hb_dat_o, 16'hF00D);
      bus.hb_ready_i = 1'b1;
      tick();
      chk("pw_d1", bus.hb_dat_o, 16'hCAFE);
      bus.hb_ready_i = 1'b0;
      tick();
      tick();
      chk("pw_ack", bus.wb_ack_o, 1);
      wb_drop();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
